// File: rtl/taptempo_pkg.sv
// Shared definitions for the tap-tempo front end: arbiter FSM encodings and
// the debounce-count derivation used by every debouncer in the block.
package taptempo_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CNT    = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    // Number of time pulses a level must stay stable before it is accepted.
    function automatic int max_count(input int pulse_ns, input int deb_ns);
        return deb_ns / pulse_ns;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority picker: returns the first set request at or after ptr,
// wrapping from N-1 back to 0. Purely combinational.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    int pos;

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        valid = 1'b0;
        idx   = ptr;
        pos   = 0;
        // Walk from farthest to nearest so the nearest hit to ptr is written last.
        for (int k = N - 1; k >= 0; k--) begin
            pos = (int'(ptr) + k) % N;
            if (req[pos]) begin
                valid = 1'b1;
                idx   = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/debounce_arbiter.sv
// Debounces N_BTN buttons with one shared stability counter, handed out
// round-robin to whichever channel's raw level disagrees with its debounced level.
module debounce_arbiter
    import taptempo_pkg::*;
#(
    parameter int N_BTN           = 4,
    parameter int PULSE_PER_NS    = 4096,
    parameter int DEBOUNCE_PER_NS = 16_777_216,
    localparam int MAX_COUNT      = max_count(PULSE_PER_NS, DEBOUNCE_PER_NS),
    localparam int CNT_W          = $clog2(MAX_COUNT + 1),
    localparam int IDX_W          = $clog2(N_BTN)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             tp_i,
    input  logic [N_BTN-1:0] btn_i,
    output logic [N_BTN-1:0] btn_o,
    output logic [N_BTN-1:0] press_o,
    output logic [N_BTN-1:0] release_o,
    output logic             busy_o,
    output logic [IDX_W-1:0] grant_o
);

    state_t           state;
    logic [CNT_W-1:0] counter;
    logic             target;
    logic [IDX_W-1:0] rr_ptr;

    logic [N_BTN-1:0] req;
    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;

    assign req    = btn_i ^ btn_o;
    assign busy_o = (state != S_IDLE);

    rr_pick #(.N(N_BTN), .IDX_W(IDX_W)) u_pick (
        .req   (req),
        .ptr   (rr_ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] g);
        return (int'(g) == N_BTN - 1) ? '0 : g + IDX_W'(1);
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= S_IDLE;
            counter   <= '0;
            target    <= 1'b0;
            rr_ptr    <= '0;
            grant_o   <= '0;
            btn_o     <= '0;
            press_o   <= '0;
            release_o <= '0;
        end else begin
            // Pulses default low so each one lasts exactly one cycle.
            press_o   <= '0;
            release_o <= '0;
            case (state)
                S_IDLE: begin
                    if (pick_valid) begin
                        grant_o <= pick_idx;
                        target  <= btn_i[pick_idx];
                        counter <= '0;
                        state   <= S_CNT;
                    end
                end
                S_CNT: begin
                    // A bounce during the count wins over a coincident tp_i.
                    if (btn_i[grant_o] != target) begin
                        rr_ptr <= wrap_inc(grant_o);
                        state  <= S_IDLE;
                    end else if (counter == CNT_W'(MAX_COUNT)) begin
                        state <= S_COMMIT;
                    end else if (tp_i) begin
                        counter <= counter + CNT_W'(1);
                    end
                end
                S_COMMIT: begin
                    btn_o[grant_o] <= target;
                    if (target) press_o[grant_o]   <= 1'b1;
                    else        release_o[grant_o] <= 1'b1;
                    rr_ptr <= wrap_inc(grant_o);
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_debounce_arbiter.sv
// Directed bench for debounce_arbiter with MAX_COUNT=4 and tp_i every 8 clocks;
// tp_i lands on every clock edge whose index is a multiple of 8.
module tb_debounce_arbiter;
    import taptempo_pkg::*;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       tp_i  = 1'b0;
    logic [3:0] btn_i = 4'b0;
    logic [3:0] btn_o, press_o, release_o;
    logic       busy_o;
    logic [1:0] grant_o;

    debounce_arbiter #(
        .N_BTN           (4),
        .PULSE_PER_NS    (4096),
        .DEBOUNCE_PER_NS (16384)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .tp_i      (tp_i),
        .btn_i     (btn_i),
        .btn_o     (btn_o),
        .press_o   (press_o),
        .release_o (release_o),
        .busy_o    (busy_o),
        .grant_o   (grant_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;
    int ncyc    = 0;
    int t0      = 0;
    int multi   = 0;
    int press_tot [4] = '{default: 0};
    int rel_tot   [4] = '{default: 0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: sample pulses just after the edge, then drive tp_i for the next edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
        ncyc++;
        for (int i = 0; i < 4; i++) begin
            press_tot[i] += 32'(press_o[i]);
            rel_tot[i]   += 32'(release_o[i]);
        end
        if ($countones(press_o | release_o) > 1) multi++;
        tp_i = (ncyc % 8 == 7);
    endtask

    task automatic start();
        while (ncyc % 8 != 0) tick();
        t0 = ncyc;
    endtask

    task automatic upto(input int n);
        while (ncyc - t0 < n) tick();
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        check("rst_btn",   32'(btn_o),     32'h0);
        check("rst_press", 32'(press_o),   32'h0);
        check("rst_rel",   32'(release_o), 32'h0);
        check("rst_busy",  32'(busy_o),    32'h0);
        check("rst_grant", 32'(grant_o),   32'h0);
        rst_i = 1'b0;

        // 1: press then release on ch0; commit 34 edges after the change
        start(); btn_i = 4'b0001;
        upto(10); check("t1_busy", 32'(busy_o), 32'h1); check("t1_grant", 32'(grant_o), 32'h0);
        upto(33); check("t1_early_btn", 32'(btn_o), 32'h0); check("t1_early_press", 32'(press_o), 32'h0);
        upto(34); check("t1_btn", 32'(btn_o), 32'h1);       check("t1_press", 32'(press_o), 32'h1);
        upto(35); check("t1_press_off", 32'(press_o), 32'h0);
        start(); btn_i = 4'b0000;
        upto(34); check("t1_rel_btn", 32'(btn_o), 32'h0);  check("t1_rel", 32'(release_o), 32'h1);

        // 2: ch2 bounces after one tp_i -> abort, rr_ptr becomes 3
        start(); btn_i = 4'b0100;
        upto(1); check("t2_grant", 32'(grant_o), 32'h2);
        upto(8); btn_i = 4'b0000;
        upto(9);  check("t2_busy", 32'(busy_o), 32'h0);
        upto(40); check("t2_btn", 32'(btn_o), 32'h0); check("t2_idle", 32'(busy_o), 32'h0);

        // 4a: ch0+ch3 with rr_ptr=3 -> ch3 first, then ch0
        start(); btn_i = 4'b1001;
        upto(1);  check("t4a_grant3", 32'(grant_o), 32'h3);
        upto(34); check("t4a_btn3", 32'(btn_o), 32'h8); check("t4a_press3", 32'(press_o), 32'h8);
        upto(35); check("t4a_grant0", 32'(grant_o), 32'h0);
        upto(66); check("t4a_btn0", 32'(btn_o), 32'h9); check("t4a_press0", 32'(press_o), 32'h1);
        // 4b: ch1 press alone, leaves rr_ptr=2
        start(); btn_i = 4'b1011;
        upto(1);  check("t4b_grant1", 32'(grant_o), 32'h1);
        upto(34); check("t4b_btn", 32'(btn_o), 32'hb);
        // 4c: rr_ptr=2, requests on ch1 and ch3 -> ch3 then ch1
        start(); btn_i = 4'b0001;
        upto(1);  check("t4c_grant3", 32'(grant_o), 32'h3);
        upto(34); check("t4c_btn3", 32'(btn_o), 32'h3); check("t4c_rel3", 32'(release_o), 32'h8);
        upto(35); check("t4c_grant1", 32'(grant_o), 32'h1);
        upto(66); check("t4c_btn1", 32'(btn_o), 32'h1); check("t4c_rel1", 32'(release_o), 32'h2);
        // 4d: release ch0
        start(); btn_i = 4'b0000;
        upto(34); check("t4d_btn", 32'(btn_o), 32'h0); check("t4d_rel0", 32'(release_o), 32'h1);

        // 5: mismatch coincides with the first tp_i -> abort, counter untouched
        start(); btn_i = 4'b0001;
        upto(7); btn_i = 4'b0000;
        upto(8);
        check("t5_busy",  32'(busy_o),      32'h0);
        check("t5_state", 32'(dut.state),   32'(S_IDLE));
        check("t5_cnt",   32'(dut.counter), 32'h0);
        upto(40); check("t5_btn", 32'(btn_o), 32'h0);

        // 6: reset while ch2 is counting at counter=3
        start(); btn_i = 4'b0100;
        upto(24);
        check("t6_pre_grant", 32'(grant_o),     32'h2);
        check("t6_pre_cnt",   32'(dut.counter), 32'h3);
        rst_i = 1'b1; btn_i = 4'b0000;
        upto(25);
        check("t6_btn",   32'(btn_o),     32'h0);
        check("t6_press", 32'(press_o),   32'h0);
        check("t6_rel",   32'(release_o), 32'h0);
        check("t6_busy",  32'(busy_o),    32'h0);
        check("t6_grant", 32'(grant_o),   32'h0);
        check("t6_state", 32'(dut.state), 32'(S_IDLE));
        rst_i = 1'b0;
        upto(60); check("t6_after_busy", 32'(busy_o), 32'h0); check("t6_after_btn", 32'(btn_o), 32'h0);

        // 3: all four pressed at once from reset -> commits 0,1,2,3
        start(); btn_i = 4'b1111;
        upto(20);  check("t3_busy0", 32'(busy_o), 32'h1);
        upto(34);  check("t3_btn0", 32'(btn_o), 32'h1); check("t3_press0", 32'(press_o), 32'h1);
        upto(50);  check("t3_busy1", 32'(busy_o), 32'h1); check("t3_grant1", 32'(grant_o), 32'h1);
        upto(66);  check("t3_btn1", 32'(btn_o), 32'h3); check("t3_press1", 32'(press_o), 32'h2);
        upto(80);  check("t3_busy2", 32'(busy_o), 32'h1); check("t3_grant2", 32'(grant_o), 32'h2);
        upto(98);  check("t3_btn2", 32'(btn_o), 32'h7); check("t3_press2", 32'(press_o), 32'h4);
        upto(110); check("t3_busy3", 32'(busy_o), 32'h1); check("t3_grant3", 32'(grant_o), 32'h3);
        upto(130); check("t3_btn3", 32'(btn_o), 32'hf); check("t3_press3", 32'(press_o), 32'h8);
        upto(140); check("t3_idle", 32'(busy_o), 32'h0);

        // Pulse totals across the whole run and the one-hot pulse property
        check("tot_press0", 32'(press_tot[0]), 32'd3);
        check("tot_press1", 32'(press_tot[1]), 32'd2);
        check("tot_press2", 32'(press_tot[2]), 32'd1);
        check("tot_press3", 32'(press_tot[3]), 32'd2);
        check("tot_rel0",   32'(rel_tot[0]),   32'd2);
        check("tot_rel1",   32'(rel_tot[1]),   32'd1);
        check("tot_rel2",   32'(rel_tot[2]),   32'd0);
        check("tot_rel3",   32'(rel_tot[3]),   32'd1);
        check("pulse_onehot", 32'(multi), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
